// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting timer with prescaler, one-shot/periodic modes,
// a sticky expiry flag and a level interrupt.
module mmio_timer #(
  parameter int PRESCALE = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  logic        en_q, en_d, rl_q, rl_d, ie_q, ie_d, exp_q, exp_d;
  logic [31:0] load_q, load_d, count_q, count_d;
  logic [15:0] pre_q, pre_d;
  logic        tick, wr_ctrl, wr_load, wr_stat;
  always_comb begin
    wr_ctrl = we && addr == 2'd0;
    wr_load = we && addr == 2'd1;
    wr_stat = we && addr == 2'd3;
    tick    = en_q && pre_q == 16'(PRESCALE - 1);
    en_d    = en_q;
    rl_d    = rl_q;
    ie_d    = ie_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q && !(wr_stat && wdata[0]);
    // a LOAD write on a tick edge suppresses the decrement and any expiry
    if (tick && !wr_load && count_q != 32'd0) begin
      if (count_q == 32'd1) begin
        exp_d   = 1'b1;
        count_d = rl_q ? load_q : 32'd0;
        en_d    = rl_q;
      end else begin
        count_d = count_q - 32'd1;
      end
    end
    if (wr_ctrl) {ie_d, rl_d, en_d} = wdata[2:0];
    if (wr_load) begin
      load_d  = wdata;
      count_d = wdata;
    end
    // prescaler parks at 0 whenever the timer is (or is about to be) disabled
    pre_d = (!en_q || !en_d || tick || wr_load) ? 16'd0 : pre_q + 16'd1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q    <= 1'b0;
      rl_q    <= 1'b0;
      ie_q    <= 1'b0;
      exp_q   <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
      pre_q   <= '0;
    end else begin
      en_q    <= en_d;
      rl_q    <= rl_d;
      ie_q    <= ie_d;
      exp_q   <= exp_d;
      load_q  <= load_d;
      count_q <= count_d;
      pre_q   <= pre_d;
    end
  end
  assign rdata = addr == 2'd0 ? {29'd0, ie_q, rl_q, en_q} :
                 addr == 2'd1 ? load_q :
                 addr == 2'd2 ? count_q : {31'd0, exp_q};
  assign irq = exp_q && ie_q;
endmodule
